// File: rtl/tt_pkg.sv
// Shared types and geometry for the truth-table sweeper slice.
package tt_pkg;

  localparam int N_IN_D   = 3;
  localparam int N_FUNC_D = 6;
  localparam int N_VEC    = 1 << N_IN_D;
  localparam int TT_W     = N_FUNC_D * N_VEC;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } tt_state_t;

  function automatic logic [N_VEC-1:0] tt_slice(
    input logic [TT_W-1:0] data,
    input int              f
  );
    return data[f*N_VEC +: N_VEC];
  endfunction

endpackage

// File: rtl/tt_vec_counter.sv
// Settle-cycle counter and input-vector index for one sweep.
module tt_vec_counter
  import tt_pkg::*;
#(
  parameter int N_IN   = N_IN_D,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  output logic [N_IN-1:0] idx,
  output logic            last_vec,
  output logic            sample_en
);

  localparam int CW = $clog2(SETTLE + 1);

  logic [CW-1:0] cnt;

  assign last_vec  = &idx;
  assign sample_en = en && (cnt == CW'(SETTLE - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      idx <= '0;
      cnt <= '0;
    end else if (en) begin
      if (sample_en) begin
        cnt <= '0;
        // idx parks on the last vector; the FSM leaves SWEEP here
        if (!last_vec) idx <= idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps xyz through every combination, captures a packed truth
// table of the functions under test and compares it to exp_tt.
module truth_table_sweeper
  import tt_pkg::*;
#(
  parameter int N_IN   = N_IN_D,
  parameter int N_FUNC = N_FUNC_D,
  parameter int SETTLE = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           abort,
  output logic [N_IN-1:0]                xyz,
  input  logic [N_FUNC-1:0]              f_in,
  input  logic [N_FUNC*(1<<N_IN)-1:0]    exp_tt,
  output logic                           busy,
  output logic                           tt_valid,
  input  logic                           tt_ready,
  output logic [N_FUNC*(1<<N_IN)-1:0]    tt_data,
  output logic [N_FUNC-1:0]              mismatch
);

  localparam int N_V = 1 << N_IN;
  localparam int W   = N_FUNC * N_V;

  tt_state_t       state_q, state_d;
  logic [N_IN-1:0] idx;
  logic            last_vec;
  logic            sample_en;
  logic            go;
  logic            stop;
  logic            cnt_en;
  logic [W-1:0]    cap_d;
  logic [N_FUNC-1:0] diff;

  assign go     = (state_q == IDLE) && start;
  assign stop   = (state_q == SWEEP) && abort;
  assign cnt_en = (state_q == SWEEP) && !abort;

  tt_vec_counter #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (go || stop),
    .en        (cnt_en),
    .idx       (idx),
    .last_vec  (last_vec),
    .sample_en (sample_en)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = SWEEP;
      SWEEP: begin
        if (abort)                      state_d = IDLE;
        else if (sample_en && last_vec) state_d = DONE;
      end
      DONE:  if (tt_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  for (genvar f = 0; f < N_FUNC; f++) begin : g_func
    for (genvar v = 0; v < N_V; v++) begin : g_vec
      assign cap_d[f*N_V+v] = (sample_en && idx == N_IN'(v)) ?
                              f_in[f] : tt_data[f*N_V+v];
    end
    assign diff[f] = tt_data[f*N_V +: N_V] != exp_tt[f*N_V +: N_V];
  end

  always_ff @(posedge clk) begin
    if (!rst_n || go) tt_data <= '0;
    else              tt_data <= cap_d;
  end

  assign busy     = (state_q == SWEEP);
  assign tt_valid = (state_q == DONE);
  assign xyz      = (state_q == IDLE) ? '0 : idx;
  assign mismatch = tt_valid ? diff : '0;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: fixed gate functions feed two sweepers
// (SETTLE=1 and SETTLE=3); expected tables are queued at start.
module tb_truth_table_sweeper;
  import tt_pkg::*;

  localparam logic [47:0] GOLD = 48'hCE2A8A04201F;

  typedef struct {
    logic [47:0] tt;
    logic [5:0]  mm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        start = 0, abort = 0, tt_ready = 0;
  logic [47:0] exp_tt = '0;
  logic [2:0]  xyz;
  logic [5:0]  f_in;
  logic        busy, tt_valid;
  logic [47:0] tt_data;
  logic [5:0]  mismatch;

  logic        start3 = 0, abort3 = 0, ready3 = 0;
  logic [2:0]  xyz3;
  logic [5:0]  f_in3;
  logic        busy3, valid3;
  logic [47:0] tt3;
  logic [5:0]  mm3;

  always #5 clk = ~clk;

  function automatic logic [5:0] fx(input logic [2:0] v);
    logic x, y, z;
    {x, y, z} = v;
    fx[0] = ~x | (~y & ~z);
    fx[1] = x & ~(y | ~z);
    fx[2] = ~(x | ~y) & ~z;
    fx[3] = ~(x & ~y) & z;
    fx[4] = ~(x & y) & z;
    fx[5] = (~x | y) & (y | z);
  endfunction

  function automatic logic [47:0] model_tt(input int upto);
    logic [47:0] t = '0;
    for (int v = 0; v < upto; v++) begin
      logic [5:0] o = fx(3'(v));
      for (int f = 0; f < 6; f++) t[f*8+v] = o[f];
    end
    return t;
  endfunction

  function automatic logic [5:0] model_mm(input logic [47:0] t,
                                          input logic [47:0] e);
    logic [5:0] m;
    for (int f = 0; f < 6; f++) m[f] = tt_slice(t, f) != tt_slice(e, f);
    return m;
  endfunction

  assign f_in  = fx(xyz);
  assign f_in3 = fx(xyz3);

  truth_table_sweeper #(.N_IN(3), .N_FUNC(6), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .xyz(xyz), .f_in(f_in), .exp_tt(exp_tt), .busy(busy),
    .tt_valid(tt_valid), .tt_ready(tt_ready), .tt_data(tt_data),
    .mismatch(mismatch)
  );

  truth_table_sweeper #(.N_IN(3), .N_FUNC(6), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
    .xyz(xyz3), .f_in(f_in3), .exp_tt(exp_tt), .busy(busy3),
    .tt_valid(valid3), .tt_ready(ready3), .tt_data(tt3),
    .mismatch(mm3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    checks++;
    if ({xyz, busy, tt_valid, tt_data, mismatch} !== '0) begin
      errors++;
      $display("FAIL reset: xyz=%0d busy=%b valid=%b tt=%h mm=%b want all 0",
               xyz, busy, tt_valid, tt_data, mismatch);
    end
  endtask

  // Start a sweep, check the xyz ramp and latency, leave DUT in DONE.
  task automatic run_sweep(input logic [47:0] e, input bit poke_start);
    exp_t x;
    exp_tt = e;
    start  = 1;
    tick();
    start = poke_start;
    x.tt = model_tt(8);
    x.mm = model_mm(x.tt, e);
    sb.push_back(x);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (xyz !== 3'(k) || busy !== 1'b1 || tt_valid !== 1'b0) begin
        errors++;
        $display("FAIL sweep_step%0d: xyz=%0d busy=%b valid=%b want %0d 1 0",
                 k, xyz, busy, tt_valid, k);
      end
      tick();
    end
    start = 0;
    checks++;
    if (tt_valid !== 1'b1 || busy !== 1'b0 || xyz !== 3'd7) begin
      errors++;
      $display("FAIL latency: valid=%b busy=%b xyz=%0d want 1 0 7",
               tt_valid, busy, xyz);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: size=0 want 1");
    end else begin
      x = sb.pop_front();
      if (tt_data !== x.tt || mismatch !== x.mm) begin
        errors++;
        $display("FAIL result: tt=%h mm=%b want tt=%h mm=%b",
                 tt_data, mismatch, x.tt, x.mm);
      end
    end
  endtask

  task automatic handshake();
    logic [47:0] held = tt_data;
    tt_ready = 1;
    tick();
    tt_ready = 0;
    checks++;
    if (tt_valid !== 1'b0 || busy !== 1'b0 || tt_data !== held ||
        mismatch !== 6'b0) begin
      errors++;
      $display("FAIL handshake: valid=%b busy=%b tt=%h mm=%b want 0 0 %h 0",
               tt_valid, busy, tt_data, mismatch, held);
    end
  endtask

  task automatic test_sweep();
    run_sweep(GOLD, 0);
    checks++;
    if (tt_data !== GOLD || mismatch !== 6'b0) begin
      errors++;
      $display("FAIL gold_table: tt=%h mm=%b want %h 0",
               tt_data, mismatch, GOLD);
    end
    handshake();
  endtask

  task automatic test_mismatch();
    logic [47:0] e = {GOLD[47:8], 8'h1E};
    run_sweep(e, 0);
    checks++;
    if (mismatch !== 6'b000001) begin
      errors++;
      $display("FAIL mismatch_f0: mm=%b want 000001", mismatch);
    end
    handshake();
  endtask

  task automatic test_hold_ready_low();
    logic [47:0] held;
    run_sweep(GOLD, 0);
    held = tt_data;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (tt_valid !== 1'b1 || tt_data !== held) begin
        errors++;
        $display("FAIL hold_%0d: valid=%b tt=%h want 1 %h",
                 k, tt_valid, tt_data, held);
      end
    end
    handshake();
  endtask

  task automatic test_start_ignored();
    run_sweep(GOLD, 1);
    // start together with the handshake must not launch a sweep
    start    = 1;
    tt_ready = 1;
    tick();
    start    = 0;
    tt_ready = 0;
    tick();
    checks++;
    if (busy !== 1'b0 || tt_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_at_handshake: busy=%b valid=%b want 0 0",
               busy, tt_valid);
    end
  endtask

  task automatic test_abort();
    logic [47:0] part = model_tt(4);
    bit seen = 0;
    start = 1;
    tick();
    start = 0;
    for (int k = 0; k < 4; k++) tick();
    checks++;
    if (xyz !== 3'd4) begin
      errors++;
      $display("FAIL abort_pre: xyz=%0d want 4", xyz);
    end
    abort = 1;
    tick();
    abort = 0;
    checks++;
    if (busy !== 1'b0 || xyz !== 3'd0 || tt_data !== part) begin
      errors++;
      $display("FAIL abort: busy=%b xyz=%0d tt=%h want 0 0 %h",
               busy, xyz, tt_data, part);
    end
    for (int k = 0; k < 12; k++) begin
      if (tt_valid) seen = 1;
      tick();
    end
    checks++;
    if (seen || tt_data !== part) begin
      errors++;
      $display("FAIL abort_after: valid_seen=%b tt=%h want 0 %h",
               seen, tt_data, part);
    end
    abort = 1;
    tick();
    abort = 0;
    checks++;
    if (tt_data !== part || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: tt=%h busy=%b want %h 0",
               tt_data, busy, part);
    end
  endtask

  task automatic test_settle3();
    int n = 0;
    exp_t x;
    start3 = 1;
    tick();
    start3 = 0;
    x.tt = model_tt(8);
    x.mm = model_mm(x.tt, exp_tt);
    sb.push_back(x);
    while (!valid3 && n < 100) begin
      checks++;
      if (n < 24 && (xyz3 !== 3'(n / 3) || busy3 !== 1'b1)) begin
        errors++;
        $display("FAIL settle3_step%0d: xyz=%0d busy=%b want %0d 1",
                 n, xyz3, busy3, n / 3);
      end
      tick();
      n++;
    end
    checks++;
    if (n != 24) begin
      errors++;
      $display("FAIL settle3_latency: cycles=%0d want 24", n);
    end
    x = sb.pop_front();
    checks++;
    if (tt3 !== x.tt || mm3 !== x.mm) begin
      errors++;
      $display("FAIL settle3_result: tt=%h mm=%b want %h %b",
               tt3, mm3, x.tt, x.mm);
    end
    ready3 = 1;
    tick();
    ready3 = 0;
    checks++;
    if (valid3 !== 1'b0 || busy3 !== 1'b0) begin
      errors++;
      $display("FAIL settle3_hs: valid=%b busy=%b want 0 0", valid3, busy3);
    end
  endtask

  task automatic test_reset_mid_sweep();
    start = 1;
    tick();
    start = 0;
    tick();
    tick();
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    checks++;
    if ({xyz, busy, tt_valid, tt_data, mismatch} !== '0) begin
      errors++;
      $display("FAIL reset_mid: xyz=%0d busy=%b valid=%b tt=%h mm=%b",
               xyz, busy, tt_valid, tt_data, mismatch);
    end
  endtask

  task automatic test_back_to_back();
    run_sweep(GOLD, 0);
    handshake();
    run_sweep({GOLD[47:40] ^ 8'hFF, GOLD[39:0]}, 0);
    checks++;
    if (mismatch !== 6'b100000) begin
      errors++;
      $display("FAIL b2b_mm: mm=%b want 100000", mismatch);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_mismatch();
    test_hold_ready_low();
    test_start_ignored();
    test_abort();
    test_settle3();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Automatic stimulus/capture stage for the team's combinational gate-level function blocks (3-input boolean functions of x, y, z).
- Sits directly upstream and downstream of the function-under-test array:
  - drives the input vector through every combination in ascending order;
  - samples each function output per combination and assembles a packed truth table;
  - flags per-function mismatches against an expected table.
- Replaces hand-written #1 stimulus sequences with a synthesizable, handshaked sweep.

Parameters:
- N_IN, default 3: number of function inputs. Input vector bit N_IN-1 is x, bit 0 is z.
- N_FUNC, default 6: number of functions sampled in parallel.
- SETTLE, default 1: clock cycles each vector is held before sampling. Legal range is >= 1.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: synchronous, active-low reset.
- start, input, 1: begin a sweep. Sampled only in IDLE.
- abort, input, 1: cancel a sweep in progress.
- xyz, output, N_IN: registered input vector driven to the functions under test.
- f_in, input, N_FUNC: function outputs. Combinational from xyz.
- exp_tt, input, N_FUNC*2^N_IN: expected truth tables, same packing as tt_data.
- busy, output, 1: high while sweeping.
- tt_valid, output, 1: truth table complete and held.
- tt_ready, input, 1: consumer accepts tt_data.
- tt_data, output, N_FUNC*2^N_IN: captured truth tables. Bit [f*2^N_IN + idx] is the output of function f for xyz = idx.
- mismatch, output, N_FUNC: bit f = 1 when function f's captured table differs from its exp_tt slice. Forced to 0 while tt_valid = 0.

Behaviour:
- Reset (rst_n = 0 at a rising edge): state IDLE; xyz, tt_data, tt_valid, busy, mismatch all 0; idx = 0; settle counter = 0. Reset overrides every other input, including mid-sweep.
- States: IDLE, SWEEP, DONE.
- IDLE:
  - xyz = 0, busy = 0.
  - On start = 1: tt_data <= 0, idx <= 0, cnt <= 0, state <= SWEEP.
- SWEEP:
  - busy = 1; xyz = idx.
  - Each cycle: cnt <= cnt + 1.
  - When cnt == SETTLE-1, at that edge:
    - tt_data[f*2^N_IN + idx] <= f_in[f] for every f;
    - cnt <= 0;
    - if idx == 2^N_IN - 1, state <= DONE;
    - otherwise idx <= idx + 1.
  - Each vector occupies exactly SETTLE cycles; no gap between vectors.
  - start is ignored.
- Latency: start accepted at edge E0 -> tt_valid high after edge E0 + 2^N_IN*SETTLE. With defaults, 8 cycles after the start edge.
- DONE:
  - busy = 0, tt_valid = 1, xyz holds last vector (all ones).
  - tt_data stable.
  - mismatch[f] = (tt_data slice f != exp_tt slice f), combinational from the tt_data register and exp_tt.
- Handshake: on tt_valid & tt_ready at an edge, state <= IDLE, so tt_valid = 0 from the next cycle.
  - tt_data retains its value until the next accepted start.
  - tt_ready outside DONE is ignored.
  - start asserted in the same cycle as the DONE handshake is ignored; it must be re-asserted in IDLE.
- Abort:
  - abort = 1 in SWEEP: state <= IDLE, idx <= 0, cnt <= 0. Partial tt_data is kept; tt_valid never asserts.
  - abort in IDLE or DONE has no effect.
  - abort has priority over the final-sample transition to DONE.
- Wrap: idx never wraps. The sweep ends at 2^N_IN - 1.
- Width: idx and xyz are N_IN bits. cnt is clog2(SETTLE+1) bits. f_in is sampled exactly once per vector.

Decomposition:
- Shared package tt_pkg:
  - state enum {IDLE, SWEEP, DONE};
  - localparam N_VEC = 1 << N_IN;
  - helper function tt_slice(data, f).
- One natural sub-module: tt_vec_counter.
  - Settle counter plus index counter with clear/enable.
  - Outputs last_vec and sample_en.
  - The FSM, capture register and compare stay in the top.

Test Plan:
- Defaults, functions wired as f0 = x' + y'z', f1 = x(y + z')', f2 = (x + y')'z', f3 = (xy')'z, f4 = (xy)'z, f5 = (x' + y)(y + z).
  - start pulse -> xyz steps 0..7 one per cycle.
  - tt_valid rises 8 cycles after the start edge.
  - tt_data = 48'hCE2A8A04201F.
  - With exp_tt equal to that value -> mismatch = 0.
- Same sweep with exp_tt slice 0 = 8'h1E -> mismatch = 6'b000001. All other bits 0.
- SETTLE = 3 -> each xyz value held 3 cycles; tt_valid rises 24 cycles after the start edge; same tt_data.
- tt_ready held low for 5 cycles in DONE -> tt_valid and tt_data stable throughout. tt_ready = 1 -> tt_valid = 0 next cycle, busy = 0, tt_data unchanged.
- abort asserted while xyz = 3'b100:
  - state returns to IDLE; xyz = 0 next cycle;
  - tt_data bits for idx 0..3 captured, idx 4..7 still 0;
  - tt_valid never rises.
- rst_n = 0 for one edge mid-sweep -> all outputs 0 next cycle. start during SWEEP is ignored (no restart, no latency change).
